pn_despreader: RTL and testbench

Receive-side counterpart of the 12-bit PN spreader. The block takes the hard-decision chip stream from the demodulator and acquires chip alignment of a local copy of the 4095-chip PN sequence by serial search. It then despreads one data bit per PN period and reports lock status. It sits between the chip slicer and the receive data path.

---
 rtl/pn_pkg.sv | 30 +++
 rtl/pn_lfsr.sv | 36 +++
 rtl/pn_despreader.sv | 148 ++++++++++++++
 tb/tb_pn_despreader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pn_pkg : shared PN constants, LFSR step function and FSM encoding     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package pn_pkg;

  localparam int                   PN_WIDTH  = 12;
  localparam int                   PN_PERIOD = 4095;
  localparam logic [PN_WIDTH-1:0]  PN_TAPS   = 12'h053;
  localparam logic [PN_WIDTH-1:0]  PN_SEED   = 12'h001;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    TRACK  = 2'd2
  } pn_fsm_e;

  // Output is state[MSB]; the x^k tap reads the stage holding the chip k steps after it.
  function automatic logic [PN_WIDTH-1:0] pn_next(input logic [PN_WIDTH-1:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < PN_WIDTH; i++) begin
      fb = fb ^ (s[PN_WIDTH-1-i] & PN_TAPS[i]);
    end
    return {s[PN_WIDTH-2:0], fb};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pn_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pn_lfsr : 12-bit Fibonacci PN generator core shared with the spreader |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pn_lfsr
  import pn_pkg::*;
#(
  parameter logic [PN_WIDTH-1:0] SEED = PN_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  output logic [PN_WIDTH-1:0] state,
  output logic                chip,
  output logic                roll
);

  logic [PN_WIDTH-1:0] state_nxt;

  assign state_nxt = pn_next(state);
  assign chip      = state[PN_WIDTH-1];

  // roll is registered alongside the state so it never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
      roll  <= 1'b1;
    end else if (advance) begin
      state <= state_nxt;
      roll  <= (state_nxt == SEED);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pn_despreader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pn_despreader : serial-search PN acquisition, tracking and despread   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pn_despreader
  import pn_pkg::*;
#(
  parameter int                  ACQ_LEN     = 64,
  parameter int                  ACQ_THRESH  = 56,
  parameter int                  LOSS_THRESH = 3072,
  parameter logic [PN_WIDTH-1:0] SEED        = PN_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_chip,
  input  logic                rx_valid,
  output logic                data_out,
  output logic                data_valid,
  output logic                locked,
  output logic                pn_roll,
  output logic [PN_WIDTH-1:0] state,
  output logic [PN_WIDTH-1:0] corr
);

  localparam int                   WW       = $clog2(ACQ_LEN) + 1;
  localparam logic [WW-1:0]        WIN_LAST = WW'(ACQ_LEN - 1);
  localparam logic [WW-1:0]        WIN_HI   = WW'(ACQ_THRESH);
  localparam logic [WW-1:0]        WIN_LO   = WW'(ACQ_LEN - ACQ_THRESH);
  localparam logic [PN_WIDTH-1:0]  PER_LAST = PN_WIDTH'(PN_PERIOD - 1);
  localparam logic [PN_WIDTH-1:0]  LOSS_HI  = PN_WIDTH'(LOSS_THRESH);
  localparam logic [PN_WIDTH-1:0]  LOSS_LO  = PN_WIDTH'(PN_PERIOD - LOSS_THRESH);
  localparam logic [PN_WIDTH-1:0]  HALF     = PN_WIDTH'((PN_PERIOD + 1) / 2);

  pn_fsm_e             fsm, fsm_next;
  logic                local_chip, agree, advance;
  logic                slip_pend, slip_take;
  logic                win_step, win_end, win_hit;
  logic                per_start, per_step, per_end, per_lost;
  logic [WW-1:0]       win_cnt, win_agree, win_total;
  logic [PN_WIDTH-1:0] per_cnt, per_agree, per_total;

  pn_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .state   (state),
    .chip    (local_chip),
    .roll    (pn_roll)
  );

  assign agree     = ~(rx_chip ^ local_chip);
  assign win_total = win_agree + {{(WW-1){1'b0}}, agree};
  assign win_end   = (win_cnt == WIN_LAST);
  // Either polarity of a strong window counts: a data '1' inverts every chip
  assign win_hit   = (win_total >= WIN_HI) || (win_total <= WIN_LO);
  assign per_total = per_agree + {{(PN_WIDTH-1){1'b0}}, agree};
  assign per_end   = (per_cnt == PER_LAST);
  assign per_lost  = (per_total < LOSS_HI) && (per_total > LOSS_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= SEARCH;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      SEARCH:  if (rx_valid && !slip_pend && win_end && win_hit) fsm_next = ALIGN;
      ALIGN:   if (rx_valid && pn_roll)                         fsm_next = TRACK;
      TRACK:   if (rx_valid && per_end && per_lost)             fsm_next = SEARCH;
      default: fsm_next = SEARCH;
    endcase
  end

  always_comb begin
    advance   = 1'b0;
    slip_take = 1'b0;
    win_step  = 1'b0;
    per_start = 1'b0;
    per_step  = 1'b0;
    case (fsm)
      SEARCH: begin
        slip_take = rx_valid && slip_pend;
        win_step  = rx_valid && !slip_pend;
        advance   = win_step;
      end
      ALIGN: begin
        advance   = rx_valid;
        per_start = rx_valid && pn_roll;
      end
      TRACK: begin
        advance   = rx_valid;
        per_step  = rx_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_pend  <= 1'b0;
      win_cnt    <= '0;
      win_agree  <= '0;
      per_cnt    <= '0;
      per_agree  <= '0;
      corr       <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      locked     <= (fsm_next == TRACK);
      if (slip_take) slip_pend <= 1'b0;
      if (win_step) begin
        if (win_end) begin
          win_cnt   <= '0;
          win_agree <= '0;
          slip_pend <= !win_hit;
        end else begin
          win_cnt   <= win_cnt + WW'(1);
          win_agree <= win_total;
        end
      end
      // The SEED chip itself is the first chip of the period
      if (per_start) begin
        per_cnt   <= PN_WIDTH'(1);
        per_agree <= {{(PN_WIDTH-1){1'b0}}, agree};
      end
      if (per_step) begin
        if (per_end) begin
          per_cnt   <= '0;
          per_agree <= '0;
          corr      <= per_total;
          if (!per_lost) begin
            data_out   <= (per_total < HALF);
            data_valid <= 1'b1;
          end
        end else begin
          per_cnt   <= per_cnt + PN_WIDTH'(1);
          per_agree <= per_total;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pn_despreader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pn_despreader : directed bench with a sequence-level despread model|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pn_despreader;

  localparam int ACQ_LEN     = 64;
  localparam int ACQ_THRESH  = 56;
  localparam int LOSS_THRESH = 3072;
  localparam int PERIOD      = 4095;

  logic        clk = 1'b0;
  logic        rst_n, rx_chip, rx_valid;
  logic        data_out, data_valid, locked, pn_roll;
  logic [11:0] state, corr;

  pn_despreader #(
    .ACQ_LEN(ACQ_LEN), .ACQ_THRESH(ACQ_THRESH), .LOSS_THRESH(LOSS_THRESH), .SEED(12'h001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_chip(rx_chip), .rx_valid(rx_valid),
    .data_out(data_out), .data_valid(data_valid), .locked(locked),
    .pn_roll(pn_roll), .state(state), .corr(corr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference m-sequence from the recurrence a[n+12] = a[n+6]^a[n+4]^a[n+1]^a[n]
  bit pn_ext[PERIOD+12];
  bit pn[PERIOD];

  // Sequence-level model: local phase is an index into pn[]
  int m_idx, m_mode;  // mode 0 searching, 1 waiting for sequence start, 2 tracking
  bit m_slip;
  int win_q[$];
  int per_q[$];
  bit e_data, e_valid, e_locked;
  int e_corr;

  // Transmitter: chip = pn ^ data, per period of the transmit sequence
  int tx_pos;
  bit data_pat[16];
  bit noise_on;
  int rand_period;

  int got_bits[$];
  int got_corr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [11:0] state_of(input int idx);
    logic [11:0] s;
    for (int k = 0; k < 12; k++) s[11-k] = pn[(idx + k) % PERIOD];
    return s;
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_mode = 0; m_slip = 0;
    win_q.delete(); per_q.delete();
    e_data = 0; e_valid = 0; e_locked = 0; e_corr = 0;
  endtask

  task automatic model_chip(input bit c);
    int ag, s;
    ag = (c == pn[m_idx]) ? 1 : 0;
    e_valid = 0;
    case (m_mode)
      0: begin
        if (m_slip) m_slip = 0;
        else begin
          win_q.push_back(ag);
          m_idx = (m_idx + 1) % PERIOD;
          if (win_q.size() == ACQ_LEN) begin
            s = qsum(win_q);
            win_q.delete();
            if (s >= ACQ_THRESH || s <= ACQ_LEN - ACQ_THRESH) m_mode = 1;
            else m_slip = 1;
          end
        end
      end
      1: begin
        if (m_idx == 0) begin m_mode = 2; per_q.push_back(ag); end
        m_idx = (m_idx + 1) % PERIOD;
      end
      default: begin
        per_q.push_back(ag);
        m_idx = (m_idx + 1) % PERIOD;
        if (per_q.size() == PERIOD) begin
          s = qsum(per_q);
          per_q.delete();
          e_corr = s;
          if (s < LOSS_THRESH && s > PERIOD - LOSS_THRESH) m_mode = 0;
          else begin e_data = (s < 2048); e_valid = 1; end
        end
      end
    endcase
    e_locked = (m_mode == 2);
  endtask

  function automatic bit gen_chip();
    int p;
    bit c;
    p = tx_pos / PERIOD;
    c = pn[tx_pos % PERIOD] ^ data_pat[p];
    if (p == rand_period) c = bit'($urandom_range(0, 1));
    else if (noise_on && $urandom_range(0, 9) == 0) c = ~c;
    return c;
  endfunction

  task automatic step(input bit v);
    bit c;
    @(negedge clk);
    c = v ? gen_chip() : bit'($urandom_range(0, 1));
    rx_chip  = c;
    rx_valid = v;
    if (v) begin model_chip(c); tx_pos++; end
    else e_valid = 0;
    @(posedge clk);
    #1;
    chk("data_valid", 32'(data_valid), 32'(e_valid));
    chk("data_out",   32'(data_out),   32'(e_data));
    chk("locked",     32'(locked),     32'(e_locked));
    chk("corr",       32'(corr),       32'(e_corr));
    chk("state",      32'(state),      32'(state_of(m_idx)));
    chk("pn_roll",    32'(pn_roll),    32'(m_idx == 0));
    if (data_valid) begin
      got_bits.push_back(int'(data_out));
      got_corr.push_back(int'(corr));
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data_out"},   32'(data_out),   0);
    chk({tag, "_data_valid"}, 32'(data_valid), 0);
    chk({tag, "_locked"},     32'(locked),     0);
    chk({tag, "_corr"},       32'(corr),       0);
    chk({tag, "_state"},      32'(state),      32'h001);
    chk({tag, "_pn_roll"},    32'(pn_roll),    1);
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk);
    #4;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    if (check) check_reset_values("midrun_reset");
    #29;
    rst_n = 1'b1;
    model_reset();
    got_bits.delete(); got_corr.delete();
  endtask

  task automatic set_data(input int first, input bit b0, b1, b2, b3);
    foreach (data_pat[i]) data_pat[i] = 1'b0;
    data_pat[first] = b0; data_pat[first+1] = b1; data_pat[first+2] = b2; data_pat[first+3] = b3;
  endtask

  initial begin
    logic [11:0] seed_v;
    int ones, early_seed, wrap_bad, first_lock, n;

    rst_n = 1'b0; rx_valid = 1'b0; rx_chip = 1'b0;

    seed_v = 12'h001;
    for (int k = 0; k < 12; k++) pn_ext[k] = seed_v[11-k];
    for (int i = 0; i + 12 < PERIOD + 12; i++)
      pn_ext[i+12] = pn_ext[i+6] ^ pn_ext[i+4] ^ pn_ext[i+1] ^ pn_ext[i];
    for (int i = 0; i < PERIOD; i++) pn[i] = pn_ext[i];
    ones = 0; early_seed = 0; wrap_bad = 0;
    for (int i = 0; i < PERIOD; i++) ones += int'(pn[i]);
    for (int i = 1; i < PERIOD; i++) if (state_of(i) == 12'h001) early_seed++;
    for (int k = 0; k < 12; k++) if (pn_ext[PERIOD+k] != pn_ext[k]) wrap_bad++;
    chk("model_seed_state", 32'(state_of(0)), 32'h001);
    chk("model_state_6",    32'(state_of(6)), 32'h041);
    chk("model_ones",       ones, 2048);
    chk("model_early_seed", early_seed, 0);
    chk("model_wrap",       wrap_bad, 0);

    model_reset();
    #23;
    check_reset_values("por");
    #1 rst_n = 1'b1;

    // Aligned stream, zero data, then noise, a random period, and re-lock
    tx_pos = 0; noise_on = 0; rand_period = -1;
    set_data(3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);
    chk("state_after_6", 32'(state), 32'h041);
    while (tx_pos < 3 * PERIOD) step(1'b1);
    chk("aligned_nbits", got_bits.size(), 2);
    if (got_bits.size() == 2) begin
      chk("aligned_bit0", got_bits[0], 0);  chk("aligned_corr0", got_corr[0], 4095);
      chk("aligned_bit1", got_bits[1], 0);  chk("aligned_corr1", got_corr[1], 4095);
    end
    chk("aligned_locked", 32'(locked), 1);

    got_bits.delete(); got_corr.delete();
    noise_on = 1;
    while (tx_pos < 5 * PERIOD) step(1'b1);
    chk("noise_nbits", got_bits.size(), 2);
    if (got_bits.size() == 2) begin
      chk("noise_bit0", got_bits[0], 1);  chk_range("noise_corr0", got_corr[0], 225, 595);
      chk("noise_bit1", got_bits[1], 0);  chk_range("noise_corr1", got_corr[1], 3500, 3870);
    end
    chk("noise_locked", 32'(locked), 1);

    got_bits.delete(); got_corr.delete();
    noise_on = 0; rand_period = 5;
    while (tx_pos < 6 * PERIOD) step(1'b1);
    chk("loss_nbits", got_bits.size(), 0);
    chk("loss_locked", 32'(locked), 0);
    chk_range("loss_corr", int'(corr), 1024, 3071);

    rand_period = -1;
    while (tx_pos < 8 * PERIOD) step(1'b1);
    chk("relock_nbits", got_bits.size(), 1);
    if (got_bits.size() == 1) begin
      chk("relock_bit", got_bits[0], 0);
      chk("relock_corr", got_corr[0], 4095);
    end
    chk("relock_locked", 32'(locked), 1);

    // Asynchronous reset in the middle of a locked period
    do_reset(1'b1);

    // Stream delayed by 40 chips; bits 1,0,1,1 sent from transmit period 2
    tx_pos = PERIOD - 40;
    set_data(2, 1'b1, 1'b0, 1'b1, 1'b1);
    first_lock = -1; n = 0;
    while (got_bits.size() < 4 && n < 30000) begin
      step(1'b1);
      n++;
      if (locked && first_lock < 0) first_lock = n;
    end
    chk("offset_nbits", got_bits.size(), 4);
    chk_range("offset_acq_chips", first_lock, 1, PERIOD * (ACQ_LEN + 1));
    if (got_bits.size() == 4) begin
      chk("offset_bit0", got_bits[0], 1);
      chk("offset_bit1", got_bits[1], 0);
      chk("offset_bit2", got_bits[2], 1);
      chk("offset_bit3", got_bits[3], 1);
      chk("offset_corr0", got_corr[0], 0);
    end

    // Same aligned zero-data run as above, with random rx_valid gaps
    do_reset(1'b0);
    tx_pos = 0;
    set_data(0, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (tx_pos < 2 * PERIOD && n < 40000) begin
      step(bit'($urandom_range(0, 1)));
      n++;
    end
    chk("gaps_nbits", got_bits.size(), 1);
    if (got_bits.size() == 1) begin
      chk("gaps_bit", got_bits[0], 0);
      chk("gaps_corr", got_corr[0], 4095);
    end
    chk("gaps_locked", 32'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
